// File: rtl/dcache_write_buffer.sv
// rtl/dcache_write_buffer.sv - posted dirty-line write-back buffer with refill forwarding
// Optional: `define WBUF_COALESCE_EN merges a write into an already-buffered copy of its line.
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ADDR_W-1:0]      cache_addr_i,
    input  logic [LINE_W-1:0]      cache_data_i,
    input  logic                   cache_enable_i,
    input  logic                   cache_write_i,
    output logic                   cache_ack_o,
    output logic [LINE_W-1:0]      cache_data_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [LINE_W-1:0]      mem_data_o,
    output logic                   mem_enable_o,
    output logic                   mem_write_o,
    input  logic                   mem_ack_i,
    input  logic [LINE_W-1:0]      mem_data_i,
    input  logic                   flush_i,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LA = ADDR_W - 5;

    typedef enum logic [1:0] {IDLE, DRAIN, READ, ACK} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ack_q, ack_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;

    logic [LA-1:0]     line_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];

    logic [LA-1:0]     req_line;
    logic              hit;
    logic [PW-1:0]     hit_idx;
    logic              wr_en;
    logic [PW-1:0]     wr_idx;
    logic              unused_ok;

    assign req_line  = cache_addr_i[ADDR_W-1:5];
    // flush_i needs no logic: an idle buffer with entries always drains.
    assign unused_ok = ^{cache_addr_i[4:0], flush_i};

    // Scan oldest to newest so the last match (newest copy) wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && line_q[head_q + PW'(i)] == req_line) begin
                hit     = 1'b1;
                hit_idx = head_q + PW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        mem_en_d   = mem_en_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wr_en      = 1'b0;
        wr_idx     = tail_q;
        unique case (state_q)
            IDLE: begin
                if (cache_enable_i && cache_write_i) begin
`ifdef WBUF_COALESCE_EN
                    if (hit) begin
                        wr_en   = 1'b1;
                        wr_idx  = hit_idx;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else
`endif
                    if (count_q != CW'(DEPTH)) begin
                        wr_en   = 1'b1;
                        tail_d  = tail_q + 1'b1;
                        count_d = count_q + 1'b1;
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        // Full: free the head first; the write stays pending on the bus.
                        state_d    = DRAIN;
                        mem_en_d   = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = {line_q[head_q], 5'b0};
                        mem_data_d = data_q[head_q];
                    end
                end else if (cache_enable_i) begin
                    if (hit) begin
                        rdata_d = data_q[hit_idx];
                        ack_d   = 1'b1;
                        state_d = ACK;
                    end else begin
                        state_d    = READ;
                        mem_en_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_line, 5'b0};
                    end
                end else if (count_q != '0) begin
                    state_d    = DRAIN;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = {line_q[head_q], 5'b0};
                    mem_data_d = data_q[head_q];
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    head_d   = head_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    mem_en_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            READ: begin
                if (mem_ack_i) begin
                    rdata_d  = mem_data_i;
                    mem_en_d = 1'b0;
                    ack_d    = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Entry storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            line_q[wr_idx] <= req_line;
            data_q[wr_idx] <= cache_data_i;
        end
    end

    assign cache_ack_o  = ack_q;
    assign cache_data_o = rdata_q;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb/tb_dcache_write_buffer.sv - scoreboard bench for dcache_write_buffer
// Reference: coherent shadow memory for reads, ordered entry queue for drains.
module tb_dcache_write_buffer;
    localparam int DEPTH  = 4;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int NLINES = 64;
`ifdef WBUF_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif
    localparam int EXP_DUP = COALESCE ? 1 : 2;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [ADDR_W-1:0] cache_addr_i = '0;
    logic [LINE_W-1:0] cache_data_i = '0;
    logic              cache_enable_i = 1'b0;
    logic              cache_write_i = 1'b0;
    logic              cache_ack_o;
    logic [LINE_W-1:0] cache_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic              mem_ack_i = 1'b0;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic              flush_i = 1'b0;
    logic              empty_o;
    logic [$clog2(DEPTH):0] count_o;

    dcache_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cache_addr_i(cache_addr_i), .cache_data_i(cache_data_i),
        .cache_enable_i(cache_enable_i), .cache_write_i(cache_write_i),
        .cache_ack_o(cache_ack_o), .cache_data_o(cache_data_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .flush_i(flush_i), .empty_o(empty_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; int line; logic [LINE_W-1:0] data; } sb_t;
    typedef struct { int line; logic [LINE_W-1:0] data; } ent_t;

    sb_t               sb_q [$];
    ent_t              model_q [$];
    logic [LINE_W-1:0] mem [NLINES];
    logic [LINE_W-1:0] shadow [NLINES];
    int                wr_cnt [NLINES];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                peak = 0;
    bit                hold_wr = 1'b0;
    bit                mem_req_seen = 1'b0;

    task automatic check_i(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_l(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] init_line(input int l);
        return {8{16'hECFA, l[15:0]}};
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int l);
        return ADDR_W'(l) << 5;
    endfunction

    function automatic bit buffered(input int l);
        foreach (model_q[i]) if (model_q[i].line == l) return 1'b1;
        return 1'b0;
    endfunction

    // An accepted write either refreshes its buffered copy (coalescing) or joins the tail.
    task automatic model_write(input int l, input logic [LINE_W-1:0] d);
        int idx;
        ent_t e;
        idx = -1;
        if (COALESCE) foreach (model_q[i]) if (model_q[i].line == l) idx = i;
        if (idx >= 0) model_q[idx].data = d;
        else begin
            e.line = l;
            e.data = d;
            model_q.push_back(e);
        end
        shadow[l] = d;
    endtask

    initial begin : monitor
        sb_t it;
        forever begin
            @(negedge clk);
            if (!rst_i && cache_ack_o) begin
                check_i("ack_has_expectation", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    it = sb_q.pop_front();
                    if (it.wr) model_write(it.line, it.data);
                    else check_l("read_data", cache_data_o, it.data);
                end
            end
            if (!rst_i && int'(count_o) > peak) peak = int'(count_o);
        end
    end

    initial begin : memory
        int lat;
        int ml;
        ent_t e;
        lat = 0;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (rst_i || !mem_enable_o) begin
                lat = $urandom_range(0, 3);
            end else begin
                mem_req_seen = 1'b1;
                if (lat > 0) begin
                    lat--;
                end else if (!(hold_wr && mem_write_o)) begin
                    ml = int'(mem_addr_o[10:5]);
                    if (mem_write_o) begin
                        check_i("drain_pending", 32'(model_q.size() != 0), 1);
                        if (model_q.size() != 0) begin
                            e = model_q.pop_front();
                            check_i("drain_addr", mem_addr_o, addr_of(e.line));
                            check_l("drain_data", mem_data_o, e.data);
                        end
                        mem[ml] = mem_data_o;
                        wr_cnt[ml]++;
                    end else begin
                        check_i("miss_not_buffered", 32'(buffered(ml)), 0);
                        mem_data_i = mem[ml];
                    end
                    mem_ack_i = 1'b1;
                end
            end
        end
    end

    task automatic req(input bit wr, input int line, input logic [LINE_W-1:0] d, output int lat);
        sb_t it;
        bit got;
        @(negedge clk);
        it.wr   = wr;
        it.line = line;
        it.data = wr ? d : shadow[line];
        sb_q.push_back(it);
        cache_addr_i   = addr_of(line) | ADDR_W'($urandom_range(0, 31));
        cache_data_i   = wr ? d : rand_line();
        cache_write_i  = wr;
        cache_enable_i = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            got = cache_ack_o;
        end
        cache_enable_i = 1'b0;
        check_i("req_acked", 32'(got), 1);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!empty_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_i(name, 32'(empty_o), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_i({tag, "_cache_ack"}, 32'(cache_ack_o), 0);
        check_l({tag, "_cache_data"}, cache_data_o, '0);
        check_i({tag, "_mem_enable"}, 32'(mem_enable_o), 0);
        check_i({tag, "_mem_write"}, 32'(mem_write_o), 0);
        check_i({tag, "_mem_addr"}, mem_addr_o, 0);
        check_l({tag, "_mem_data"}, mem_data_o, '0);
        check_i({tag, "_empty"}, 32'(empty_o), 1);
        check_i({tag, "_count"}, 32'(count_o), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat;
        int lat5;
        int n;
        bit wr;
        int l;
        logic [LINE_W-1:0] line_b;
        for (int i = 0; i < NLINES; i++) begin
            mem[i]    = init_line(i);
            shadow[i] = init_line(i);
            wr_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        hold_wr = 1'b1;
        req(1'b1, 16, {32{8'hAA}}, lat);
        check_i("wr_ack_latency", lat, 1);
        check_i("count_after_wr", 32'(count_o), 1);
        check_i("not_empty_after_wr", 32'(empty_o), 0);
        repeat (5) @(negedge clk);
        check_l("mem16_before_ack", mem[16], init_line(16));
        hold_wr = 1'b0;
        wait_empty("drain_0200_empty");
        check_l("mem16_after_drain", mem[16], {32{8'hAA}});

        hold_wr = 1'b1;
        line_b = rand_line();
        req(1'b1, 32, line_b, lat);
        mem_req_seen = 1'b0;
        req(1'b0, 32, '0, lat);
        check_i("hit_ack_latency", lat, 1);
        check_i("hit_no_mem_req", 32'(mem_req_seen), 0);
        hold_wr = 1'b0;
        wait_empty("hit_drain_empty");

        hold_wr = 1'b1;
        req(1'b1, 3, rand_line(), lat);
        req(1'b1, 4, rand_line(), lat);
        req(1'b0, 2, '0, lat);
        check_i("miss_count_buffered", 32'(count_o), 2);
        check_i("miss_before_drain", wr_cnt[3], 0);
        hold_wr = 1'b0;
        wait_empty("miss_drain_empty");

        hold_wr = 1'b1;
        for (int i = 0; i < 4; i++) req(1'b1, 8 + i, rand_line(), lat);
        check_i("count_full", 32'(count_o), DEPTH);
        fork
            req(1'b1, 12, rand_line(), lat5);
            begin
                repeat (12) @(negedge clk);
                check_i("count_while_stalled", 32'(count_o), DEPTH);
                hold_wr = 1'b0;
            end
        join
        check_i("fifth_write_stalled", 32'(lat5 > 12), 1);
        wait_empty("full_drain_empty");

        hold_wr = 1'b1;
        wr_cnt[1] = 0;
        req(1'b1, 1, {32{8'h11}}, lat);
        req(1'b1, 1, {32{8'h22}}, lat);
        check_i("dup_count", 32'(count_o), EXP_DUP);
        hold_wr = 1'b0;
        flush_i = 1'b1;
        wait_empty("dup_drain_empty");
        flush_i = 1'b0;
        check_i("dup_mem_writes", wr_cnt[1], EXP_DUP);
        check_l("dup_mem_line", mem[1], {32{8'h22}});

        for (int k = 0; k < 200; k++) begin
            wr = 1'($urandom_range(0, 1));
            l  = $urandom_range(0, 7);
            req(wr, l, rand_line(), lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        flush_i = 1'b1;
        wait_empty("random_final_empty");
        flush_i = 1'b0;
        for (int k = 0; k < 8; k++) check_l("random_mem_coherent", mem[k], shadow[k]);

        hold_wr = 1'b1;
        req(1'b1, 5, rand_line(), lat);
        n = 0;
        while (!mem_enable_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_i("drain_started", 32'(mem_enable_o), 1);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        hold_wr = 1'b0;
        mem_req_seen = 1'b0;
        repeat (20) @(negedge clk);
        check_i("no_req_after_reset", 32'(mem_req_seen), 0);
        check_i("empty_after_reset", 32'(empty_o), 1);

        check_i("scoreboard_drained", sb_q.size(), 0);
        check_i("count_peak", peak, DEPTH);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
